// File: rtl/multi_channel_par_to_ser.sv
// multi_channel_par_to_ser: N-lane parallel-to-serial converter with a one-word valid/ready holding buffer.
// Optional clock-pattern lane is built when SER_CLOCK_LANE_EN is defined.
module multi_channel_par_to_ser #(
    parameter int WORD_WIDTH = 10,
    parameter int CHANNELS = 3,
    parameter bit LSB_FIRST = 1'b1,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                           serial_clock,
    input  logic                           reset_n,
    input  logic [CHANNELS*WORD_WIDTH-1:0] parallel,
    input  logic                           parallel_valid,
    output logic                           parallel_ready,
    output logic [CHANNELS-1:0]            serial,
    output logic                           word_start,
`ifdef SER_CLOCK_LANE_EN
    output logic                           serial_clock_lane,
`endif
    output logic                           underflow
);
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);
    logic [CW-1:0] bit_count, next_count;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0] shift, holding;
    logic hold_full, wrap, accept;
    always_comb begin
        wrap = bit_count == LAST;
        next_count = wrap ? '0 : bit_count + 1'b1;
        parallel_ready = !hold_full || wrap;
        accept = parallel_valid && parallel_ready;
        word_start = bit_count == '0;
        for (int c = 0; c < CHANNELS; c++)
            serial[c] = LSB_FIRST ? shift[c][0] : shift[c][WORD_WIDTH-1];
    end
    // On the wrap edge the held word moves out while a new word may enter in the same edge.
    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_count <= '0;
            hold_full <= 1'b0;
            holding <= '0;
            shift <= {CHANNELS{IDLE_WORD}};
            underflow <= 1'b0;
        end else begin
            bit_count <= next_count;
            underflow <= wrap && !hold_full;
            hold_full <= accept || (hold_full && !wrap);
            if (accept)
                holding <= parallel;
            for (int c = 0; c < CHANNELS; c++)
                shift[c] <= wrap ? (hold_full ? holding[c] : IDLE_WORD)
                          : LSB_FIRST ? shift[c] >> 1 : shift[c] << 1;
        end
    end
`ifdef SER_CLOCK_LANE_EN
    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n)
            serial_clock_lane <= 1'b1;
        else
            serial_clock_lane <= next_count < CW'(WORD_WIDTH / 2);
    end
`endif
endmodule

// File: tb/tb_multi_channel_par_to_ser.sv
// tb_multi_channel_par_to_ser: checks a default 3x10 LSB-first instance and a 1x8 MSB-first instance
// against a word-stream model built from frames, a pending-word queue and bit positions.
module tb_multi_channel_par_to_ser;
    localparam logic [9:0] IDLE_A = 10'b1101010100;
    localparam logic [7:0] IDLE_B = 8'b10110100;
    localparam logic [29:0] IDLE_A3 = {3{IDLE_A}};
    logic clk = 1'b0, rst_n = 1'b0;
    logic [29:0] a_par = '0;
    logic a_valid = 1'b0;
    logic a_rdy, a_ws, a_uf;
    logic [2:0] a_ser;
    logic [7:0] b_par = '0;
    logic b_valid = 1'b0;
    logic b_rdy, b_ws, b_uf;
    logic [0:0] b_ser;
`ifdef SER_CLOCK_LANE_EN
    logic a_clk_lane, b_clk_lane;
`endif
    int checks = 0, errors = 0;
    int m_pos, mb_pos;
    logic [29:0] m_cur;
    logic [7:0] mb_cur;
    logic m_uf, mb_uf;
    logic [29:0] m_pend[$];
    logic [7:0] mb_pend[$];

    always #5 clk = ~clk;

    multi_channel_par_to_ser dut_a (
        .serial_clock(clk), .reset_n(rst_n), .parallel(a_par), .parallel_valid(a_valid),
        .parallel_ready(a_rdy), .serial(a_ser), .word_start(a_ws),
`ifdef SER_CLOCK_LANE_EN
        .serial_clock_lane(a_clk_lane),
`endif
        .underflow(a_uf)
    );

    multi_channel_par_to_ser #(.WORD_WIDTH(8), .CHANNELS(1), .LSB_FIRST(1'b0), .IDLE_WORD(IDLE_B)) dut_b (
        .serial_clock(clk), .reset_n(rst_n), .parallel(b_par), .parallel_valid(b_valid),
        .parallel_ready(b_rdy), .serial(b_ser), .word_start(b_ws),
`ifdef SER_CLOCK_LANE_EN
        .serial_clock_lane(b_clk_lane),
`endif
        .underflow(b_uf)
    );

    function automatic logic [2:0] ea_ser();
        logic [2:0] s;
        for (int c = 0; c < 3; c++) s[c] = m_cur[c*10 + m_pos];
        return s;
    endfunction

    function automatic logic ea_rdy();
        return m_pend.size() == 0 || m_pos == 9;
    endfunction

    function automatic logic eb_rdy();
        return mb_pend.size() == 0 || mb_pos == 7;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_cur = IDLE_A3; m_uf = 1'b0; m_pend.delete();
        mb_pos = 0; mb_cur = IDLE_B; mb_uf = 1'b0; mb_pend.delete();
    endtask

    // One clock: words are taken when the model says ready; frame boundaries pop the pending word.
    task automatic tick();
        logic acc_a, acc_b;
        acc_a = a_valid && ea_rdy();
        acc_b = b_valid && eb_rdy();
        @(posedge clk);
        m_uf = m_pos == 9 && m_pend.size() == 0;
        if (m_pos == 9) begin
            if (m_uf) m_cur = IDLE_A3; else m_cur = m_pend.pop_front();
            m_pos = 0;
        end else m_pos++;
        if (acc_a) m_pend.push_back(a_par);
        mb_uf = mb_pos == 7 && mb_pend.size() == 0;
        if (mb_pos == 7) begin
            if (mb_uf) mb_cur = IDLE_B; else mb_cur = mb_pend.pop_front();
            mb_pos = 0;
        end else mb_pos++;
        if (acc_b) mb_pend.push_back(b_par);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if ({a_rdy, a_ws, a_uf, a_ser} !== {3'b110, {3{IDLE_A[0]}}}) begin
            errors++; $display("FAIL reset_a rdy/ws/uf/ser got %b expected %b", {a_rdy, a_ws, a_uf, a_ser}, {3'b110, {3{IDLE_A[0]}}});
        end
        checks++;
        if ({b_rdy, b_ws, b_uf, b_ser} !== {3'b110, IDLE_B[7]}) begin
            errors++; $display("FAIL reset_b rdy/ws/uf/ser got %b expected %b", {b_rdy, b_ws, b_uf, b_ser}, {3'b110, IDLE_B[7]});
        end
`ifdef SER_CLOCK_LANE_EN
        checks++;
        if ({a_clk_lane, b_clk_lane} !== 2'b11) begin
            errors++; $display("FAIL reset_clk_lane got %b expected 11", {a_clk_lane, b_clk_lane});
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_pattern();
        logic [29:0] w;
        logic [2:0] e;
        int n = 0;
        w = {10'b0000011111, 10'b1111100000, 10'b1010101010};
        a_par = w; a_valid = 1'b1;
        while (!ea_rdy()) tick();
        tick();
        a_valid = 1'b0;
        while (!(m_pos == 0 && m_cur == w) && n < 25) begin tick(); n++; end
        checks++;
        if (n >= 25) begin errors++; $display("FAIL pattern_wait got %0d cycles expected <25", n); end
        for (int p = 0; p < 10; p++) begin
            e[0] = (p % 2) == 1; e[1] = p >= 5; e[2] = p < 5;
            checks++;
            if ({a_ws, a_ser} !== {p == 0, e}) begin
                errors++; $display("FAIL pattern bit%0d got ws/ser %b expected %b", p, {a_ws, a_ser}, {p == 0, e});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] w[3];
        logic [4:0] lg[$];
        logic ok;
        int k = 0, s = -1;
        for (int i = 0; i < 3; i++) begin w[i] = 30'($urandom); w[i][1:0] = 2'(i); end
        for (int t = 0; t < 80; t++) begin
            a_valid = k < 3;
            if (k < 3) a_par = w[k];
            checks++;
            if (a_rdy !== ea_rdy()) begin errors++; $display("FAIL b2b_ready cyc%0d got %b expected %b", t, a_rdy, ea_rdy()); end
            lg.push_back({a_uf, a_ws, a_ser});
            if (a_valid && ea_rdy()) k++;
            tick();
        end
        a_valid = 1'b0;
        for (int i = 0; i + 30 <= lg.size() && s < 0; i++) begin
            ok = lg[i][3];
            for (int j = 0; j < 30; j++)
                for (int c = 0; c < 3; c++) ok &= lg[i+j][c] == w[j/10][c*10 + j%10] && !lg[i+j][4];
            if (ok) s = i;
        end
        checks++;
        if (s < 0) begin errors++; $display("FAIL b2b_contiguous got no gapless 3-word run expected one (accepted %0d)", k); end
    endtask

    task automatic test_starvation();
        int nu = 0, eu = 0;
        a_par = 30'($urandom); a_valid = 1'b1;
        while (!ea_rdy()) tick();
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({a_ser, a_ws, a_rdy, a_uf} !== {ea_ser(), m_pos == 0, ea_rdy(), m_uf}) begin
                errors++; $display("FAIL starve cyc%0d got ser/ws/rdy/uf %b expected %b", i, {a_ser, a_ws, a_rdy, a_uf}, {ea_ser(), m_pos == 0, ea_rdy(), m_uf});
            end
            if (a_uf) nu++;
            if (m_uf) eu++;
            tick();
        end
        checks++;
        if (nu != eu) begin errors++; $display("FAIL starve_pulses got %0d expected %0d", nu, eu); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            a_valid = 1'($urandom_range(0, 1)); a_par = 30'($urandom);
            b_valid = 1'($urandom_range(0, 1)); b_par = 8'($urandom);
            checks++;
            if ({a_ser, a_ws, a_rdy, a_uf} !== {ea_ser(), m_pos == 0, ea_rdy(), m_uf}) begin
                errors++; $display("FAIL rand_a cyc%0d got ser/ws/rdy/uf %b expected %b", i, {a_ser, a_ws, a_rdy, a_uf}, {ea_ser(), m_pos == 0, ea_rdy(), m_uf});
            end
            checks++;
            if ({b_ser, b_ws, b_rdy, b_uf} !== {mb_cur[7 - mb_pos], mb_pos == 0, eb_rdy(), mb_uf}) begin
                errors++; $display("FAIL rand_b cyc%0d got ser/ws/rdy/uf %b expected %b", i, {b_ser, b_ws, b_rdy, b_uf}, {mb_cur[7 - mb_pos], mb_pos == 0, eb_rdy(), mb_uf});
            end
`ifdef SER_CLOCK_LANE_EN
            checks++;
            if ({a_clk_lane, b_clk_lane} !== {m_pos < 5, mb_pos < 4}) begin
                errors++; $display("FAIL rand_clk_lane cyc%0d got %b expected %b", i, {a_clk_lane, b_clk_lane}, {m_pos < 5, mb_pos < 4});
            end
`endif
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [7:0] w[3];
        logic [1:0] lg[$];
        logic ok;
        int k = 0, s = -1;
        w[0] = 8'b10000000; w[1] = 8'h5a; w[2] = 8'hc3;
        repeat (20) tick();
        for (int t = 0; t < 60; t++) begin
            b_valid = k < 3;
            if (k < 3) b_par = w[k];
            checks++;
            if ({b_ser, b_ws, b_rdy, b_uf} !== {mb_cur[7 - mb_pos], mb_pos == 0, eb_rdy(), mb_uf}) begin
                errors++; $display("FAIL msb cyc%0d got ser/ws/rdy/uf %b expected %b", t, {b_ser, b_ws, b_rdy, b_uf}, {mb_cur[7 - mb_pos], mb_pos == 0, eb_rdy(), mb_uf});
            end
            lg.push_back({b_ws, b_ser[0]});
            if (b_valid && eb_rdy()) k++;
            tick();
        end
        b_valid = 1'b0;
        for (int i = 0; i + 24 <= lg.size() && s < 0; i++) begin
            ok = lg[i][1];
            for (int j = 0; j < 24; j++) ok &= lg[i+j][0] == w[j/8][7 - j%8];
            if (ok) s = i;
        end
        checks++;
        if (s < 0) begin errors++; $display("FAIL msb_contiguous got no 24-bit run expected one (accepted %0d)", k); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_par = 30'($urandom); b_par = 8'($urandom);
        while (!(m_pend.size() == 1 && m_pos == 4) && n < 40) begin tick(); n++; end
        checks++;
        if (n >= 40) begin errors++; $display("FAIL areset_setup got %0d cycles expected <40", n); end
        a_valid = 1'b0; b_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_rdy, a_ws, a_uf, a_ser, b_ser} !== {3'b110, {3{IDLE_A[0]}}, IDLE_B[7]}) begin
            errors++; $display("FAIL areset_immediate got %b expected %b", {a_rdy, a_ws, a_uf, a_ser, b_ser}, {3'b110, {3{IDLE_A[0]}}, IDLE_B[7]});
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if ({a_ser, a_ws, a_rdy, a_uf, b_ser} !== {ea_ser(), m_pos == 0, ea_rdy(), m_uf, mb_cur[7 - mb_pos]}) begin
                errors++; $display("FAIL areset_after cyc%0d got %b expected %b", i, {a_ser, a_ws, a_rdy, a_uf, b_ser}, {ea_ser(), m_pos == 0, ea_rdy(), m_uf, mb_cur[7 - mb_pos]});
            end
`ifdef SER_CLOCK_LANE_EN
            checks++;
            if (a_clk_lane !== (m_pos < 5)) begin
                errors++; $display("FAIL areset_clk_lane cyc%0d got %b expected %b", i, a_clk_lane, m_pos < 5);
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_back_to_back();
        test_starvation();
        test_random();
        test_msb_first();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
